fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage replacing the fixed 16-bit PC block of the single-cycle core. Holds the PC, issues requests to a synchronous instruction memory with one-cycle read latency, and buffers returned instructions in a small FIFO. Delivers instructions to decode over a valid/ready handshake. Accepts branch/jump redirects that flush all buffered and in-flight fetches.

## Interface
Parameters:
- PC_WIDTH, 16, PC and instruction-address width in bits.
- INSTR_WIDTH, 32, instruction width.
- RESET_VECTOR, 0, PC value after reset; low two bits must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  PC_WIDTH  read address; valid when imem_req=1.
- imem_rdata  in  INSTR_WIDTH  read data; valid the cycle after imem_req.
- redirect_valid  in  1  redirect PC this cycle (taken branch / jump).
- redirect_pc  in  PC_WIDTH  new PC; bits [1:0] ignored and treated as 0.
- out_valid  out  1  out_instr/out_pc/out_pc_plus4 valid.
- out_ready  in  1  decode accepts the head entry this cycle.
- out_instr  out  INSTR_WIDTH  instruction at FIFO head.
- out_pc  out  PC_WIDTH  address of out_instr.
- out_pc_plus4  out  PC_WIDTH  out_pc + 4, modulo 2^PC_WIDTH.

## Operation
- State: pc register, inflight flag plus inflight_pc register, FIFO of {instr, pc} entries, occupancy count.
- Issue rule: imem_req = !redirect_valid && (count + inflight − pop) < FIFO_DEPTH, where pop = out_valid && out_ready. imem_addr = pc.
- On issue: pc ← pc + 4 (wraps modulo 2^PC_WIDTH), inflight ← 1, inflight_pc ← pc. No issue: inflight ← 0.
- Response: when inflight=1, push {imem_rdata, inflight_pc} into the FIFO at the clock edge ending that cycle.
- Pop: when pop=1, FIFO head is removed. Push and pop in the same cycle are allowed at any occupancy, including full with a pending push, which the issue rule guarantees never overflows.
- Redirect (highest priority): pc ← {redirect_pc[PC_WIDTH-1:2], 2'b00}. FIFO cleared (count ← 0). The response arriving this cycle, if any, is discarded. inflight ← 0. imem_req=0 this cycle.
- A pop handshake in a redirect cycle is honoured as a pop. The entry is consumed by decode, then the flush takes effect.
- Outputs come from the FIFO head only. out_valid = (count ≠ 0). The head is held stable while out_valid && !out_ready.
- Reset state (rst=0, asynchronous): pc=RESET_VECTOR, inflight=0, count=0. Outputs: imem_req=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0. imem_addr shows RESET_VECTOR.
- Reset asserted mid-operation drops all buffered and in-flight instructions immediately. No partial state survives.

## Timing
- Cycle 0 is the first rising edge with rst=1. In cycle 0, imem_req=1 and imem_addr=RESET_VECTOR. imem_rdata is valid in cycle 1. out_valid=1 in cycle 2.
- Fetch-to-output latency is 2 cycles; redirect-to-first-new-instruction latency is 3 cycles: redirect at cycle N, request at N+1, data at N+2, out_valid at N+3.
- Steady-state throughput is 1 instruction/cycle with out_ready held high and FIFO_DEPTH ≥ 2.
- out_ready has a combinational path to imem_req. No other combinational input-to-output paths exist except redirect_valid→imem_req.
- out_valid, once asserted, drops only on pop of the last entry, redirect, or reset.

## Structure
- Shared package fetch_pkg holds:
  - INSTR_BYTES = 4.
  - The fetch-entry struct typedef {instr, pc}, parametrised via package-level width constants matching the core defaults.
- Sub-module fetch_fifo: synchronous FIFO with parametrised depth and width, plus synchronous flush and count output.
- fetch_unit owns the PC, the in-flight tracking and the issue rule.

## Test plan
- Reset release, RESET_VECTOR=0x0100, memory returns addr-tagged words, out_ready=1 → out_valid first high in cycle 2 with out_pc=0x0100. Subsequent outputs come every cycle at 0x0104, 0x0108, …; out_pc_plus4 is always out_pc+4.
- Backpressure: out_ready=0 from cycle 2 → count saturates at FIFO_DEPTH and imem_req falls to 0. Head stays at 0x0100 with no lost or duplicated entries once out_ready=1.
- Redirect while FIFO full and a response is in flight, redirect_pc=0x0043 → the FIFO empties and the in-flight word never appears. Next request is to 0x0040, and out_pc=0x0040 appears 3 cycles after the redirect.
- Wrap: PC_WIDTH=16, redirect to 0xFFFC → outputs 0xFFFC (out_pc_plus4=0x0000), then 0x0000.
- Asynchronous reset asserted mid-stream, between clock edges → out_valid and imem_req drop immediately. After release, fetch restarts at RESET_VECTOR.
- Random out_ready and sparse redirects against a scoreboard model → the output sequence exactly matches the PC-sequential stream, restarted at each redirect target.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and fetch-entry type for the instruction fetch stage
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int PC_W        = 16;
   localparam int INSTR_W     = 32;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory, redirect and decode-side handshake bundle of the fetch stage
interface fetch_if #(
   parameter int PC_WIDTH    = 16,
   parameter int INSTR_WIDTH = 32
);

   logic                   imem_req;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   redirect_valid;
   logic [PC_WIDTH-1:0]    redirect_pc;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSTR_WIDTH-1:0] out_instr;
   logic [PC_WIDTH-1:0]    out_pc;
   logic [PC_WIDTH-1:0]    out_pc_plus4;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two instruction buffer with synchronous flush and occupancy count
module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 48,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         // When full, push and pop hit the same slot; the head is read before the edge overwrites it.
         if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
         end
         if (pop) begin
            rd_d = rd_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign head_data = mem_q[rd_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, in-flight tracking, issue rule and redirect flush
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH     = 16,
   parameter int                  INSTR_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                  FIFO_DEPTH   = 2
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.master bus
);

   localparam int                  CW         = $clog2(FIFO_DEPTH) + 1;
   localparam int                  OW         = CW + 1;
   localparam int                  EW         = INSTR_WIDTH + PC_WIDTH;
   localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 1);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                inflight_q, inflight_d;
   logic [CW-1:0]       count;
   logic [EW-1:0]       head;
   logic [PC_WIDTH-1:0] head_pc;
   logic                out_valid, pop, push, issue;
   logic [OW-1:0]       occ;

   assign out_valid = (count != '0);
   assign pop       = out_valid && bus.out_ready;
   assign push      = inflight_q && !bus.redirect_valid;
   assign head_pc   = head[PC_WIDTH-1:0];

   always_comb begin
      // Slots still claimed after this cycle's pop; a new request may only take a free one.
      occ           = OW'(count) + OW'(inflight_q) - OW'(pop);
      issue         = rst && !bus.redirect_valid && (occ < OW'(FIFO_DEPTH));
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & ALIGN_MASK;
      end else if (issue) begin
         pc_d          = pc_q + STEP;
         inflight_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({bus.imem_rdata, inflight_pc_q}),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .head_data (head),
      .count     (count)
   );

   assign bus.imem_req     = issue;
   assign bus.imem_addr    = pc_q;
   assign bus.out_valid    = out_valid;
   assign bus.out_instr    = out_valid ? head[EW-1:PC_WIDTH] : '0;
   assign bus.out_pc       = out_valid ? head_pc : '0;
   assign bus.out_pc_plus4 = out_valid ? head_pc + STEP : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, corner sequences, random scoreboard
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          PW    = 16;
   localparam int          IW    = 32;
   localparam int          DEPTH = 2;
   localparam logic [15:0] RV    = 16'h0100;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

   fetch_unit #(
      .PC_WIDTH     (PW),
      .INSTR_WIDTH  (IW),
      .RESET_VECTOR (RV),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] tag(input logic [15:0] a);
      return {a ^ 16'hC3A5, a};
   endfunction

   // One-cycle-latency memory; unrequested cycles return junk so stray captures show up.
   always @(posedge clk) begin
      bus.imem_rdata <= bus.imem_req ? tag(bus.imem_addr) : 32'hDEAD_BEEF;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rdy, input logic rv, input logic [15:0] rpc);
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
   endtask

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [15:0] rpc;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic rdy, input logic rv, input logic [15:0] rpc,
                               input logic e_req, input logic [15:0] e_addr,
                               input logic e_valid, input logic [15:0] e_pc);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      return v;
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[$];
      fetch_entry_t e;
      int           lat;
      int           p;
      int           pops;
      logic [15:0]  exp_pc, start_pc, rpc;
      logic         rdy, rv;

      // cycle-by-cycle from reset release: startup, backpressure, redirect with a response in flight
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0104, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0108, 1, 16'h0100));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h010C, 1, 16'h0104));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0110, 1, 16'h0108));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0114, 1, 16'h010C));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0114, 1, 16'h010C));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0114, 1, 16'h010C));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0118, 1, 16'h0110));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h011C, 1, 16'h0114));
      tbl.push_back(mk(0, 1, 16'h0043, 0, 16'h0120, 1, 16'h0118));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0044, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0048, 1, 16'h0040));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h004C, 1, 16'h0044));

      drive(1, 0, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", bus.imem_req, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_instr", bus.out_instr, 0);
      chk("rst_pc", bus.out_pc, 0);
      chk("rst_pc_plus4", bus.out_pc_plus4, 0);
      chk("rst_addr", bus.imem_addr, RV);

      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
         #1;
         chk($sformatf("t%0d_req", i), bus.imem_req, tbl[i].e_req);
         chk($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
         chk($sformatf("t%0d_valid", i), bus.out_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            e.pc    = tbl[i].e_pc;
            e.instr = tag(tbl[i].e_pc);
            chk($sformatf("t%0d_pc", i), bus.out_pc, e.pc);
            chk($sformatf("t%0d_instr", i), bus.out_instr, e.instr);
            chk($sformatf("t%0d_pc_plus4", i), bus.out_pc_plus4, e.pc + 16'd4);
         end
         @(negedge clk);
      end

      // address-space wrap after a redirect to the last word
      drive(1, 1, 16'hFFFC);
      #1;
      chk("wrap_redir_req", bus.imem_req, 0);
      @(negedge clk);
      drive(1, 0, 16'h0000);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         #1;
         if (i == 1) chk("wrap_first_addr", bus.imem_addr, 16'hFFFC);
         if (bus.out_valid) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      chk("wrap_latency", lat, 3);
      chk("wrap_pc0", bus.out_pc, 16'hFFFC);
      chk("wrap_plus4_0", bus.out_pc_plus4, 16'h0000);
      chk("wrap_instr0", bus.out_instr, tag(16'hFFFC));
      @(negedge clk);
      #1;
      chk("wrap_pc1", bus.out_pc, 16'h0000);
      chk("wrap_plus4_1", bus.out_pc_plus4, 16'h0004);
      chk("wrap_instr1", bus.out_instr, tag(16'h0000));

      // asynchronous reset between edges while the stream is running
      #2;
      chk("async_pre_valid", bus.out_valid, 1);
      rst = 1'b0;
      #1;
      chk("async_valid_drop", bus.out_valid, 0);
      chk("async_req_drop", bus.imem_req, 0);
      chk("async_addr", bus.imem_addr, RV);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("restart_req", bus.imem_req, 1);
      chk("restart_addr", bus.imem_addr, RV);
      @(negedge clk);
      #1;
      chk("restart_c1_valid", bus.out_valid, 0);
      @(negedge clk);
      #1;
      chk("restart_c2_valid", bus.out_valid, 1);
      chk("restart_c2_pc", bus.out_pc, RV);

      // random backpressure and sparse redirects against a PC-stream scoreboard
      rst = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      exp_pc   = RV;
      start_pc = RV;
      p        = 0;
      pops     = 0;
      for (int c = 0; c < 2000; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 29) == 0);
         rpc = 16'($urandom);
         drive(rdy, rv, rpc);
         #1;
         if (rv) chk("rnd_redir_req", bus.imem_req, 0);
         if (p == 0) begin
            chk("rnd_start_addr", bus.imem_addr, start_pc);
            if (!rv) chk("rnd_start_req", bus.imem_req, 1);
         end
         if (p < 2) chk("rnd_blank_valid", bus.out_valid, 0);
         else if (p == 2) chk("rnd_first_valid", bus.out_valid, 1);
         if (bus.out_valid) begin
            chk("rnd_pc", bus.out_pc, exp_pc);
            chk("rnd_instr", bus.out_instr, tag(exp_pc));
            chk("rnd_pc_plus4", bus.out_pc_plus4, exp_pc + 16'd4);
            if (rdy) begin
               exp_pc = exp_pc + 16'd4;
               pops++;
            end
         end
         if (rv) begin
            exp_pc   = rpc & 16'hFFFC;
            start_pc = exp_pc;
            p        = 0;
         end else if (p < 3) begin
            p++;
         end
         @(negedge clk);
      end
      chk("rnd_enough_pops", pops > 300, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
